// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: FSM state encoding and default width.
// The optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_adder_cell.sv
// Combinational one-bit full adder; the only arithmetic in the serial adder datapath.
module bit_adder_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial add/subtract: one full-adder cell walks the operands LSB first, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module bit_serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q;
    logic [WIDTH-1:0]   a_sr_q;
    logic [WIDTH-1:0]   b_sr_q;
    logic [WIDTH-1:0]   sum_sr_q;
    logic [WIDTH-1:0]   sum_sr_d;
    logic               carry_q;
    logic [CNT_W-1:0]   bitcnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               cell_s;
    logic               cell_co;
    logic               last_bit_s;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q;
`endif

    bit_adder_cell u_cell (
        .x  (a_sr_q[0]),
        .y  (b_sr_q[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    assign sum_sr_d   = {cell_s, sum_sr_q[WIDTH-1:1]};
    assign last_bit_s = (bitcnt_q == CNT_W'(WIDTH - 1));

    // Sequencer: operand capture, per-bit shifting and result capture with registered handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            bitcnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1, so the carry seeds to 1 and cin is ignored
                        a_sr_q   <= a;
                        b_sr_q   <= sub ? ~b : b;
                        carry_q  <= sub ? 1'b1 : cin;
                        bitcnt_q <= '0;
                        sum_sr_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SHIFT;
                    end else begin
                        busy_q   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
                    sum_sr_q <= sum_sr_d;
                    carry_q  <= cell_co;
                    bitcnt_q <= bitcnt_q + CNT_W'(1);
                    if (last_bit_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= sum_sr_d;
                        cout_q  <= cell_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_q is the carry into the MSB while the last bit is in the cell
                        ovf_q   <= carry_q ^ cell_co;
`endif
                        state_q <= ST_DONE;
                    end else begin
                        busy_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
